glitc_config_controller: RTL and testbench



---
 rtl/glitc_config_pkg.sv | 37 +++
 rtl/glitc_config_fsm.sv | 154 +++++++++++++++
 rtl/glitc_config_controller.sv | 121 ++++++++++++
 tb/tb_glitc_config_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glitc_config_pkg.sv
// Shared encodings, register offsets and field positions for the GLITC
// configuration controller and its per-GLITC sequencers.
package glitc_config_pkg;

    typedef enum logic [2:0] {
        ST_UNCONF    = 3'd0,
        ST_PROG      = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_INIT = 3'd3,
        ST_LOAD      = 3'd4,
        ST_READY     = 3'd5,
        ST_ERROR     = 3'd6,
        ST_SENSE     = 3'd7
    } glitcState_e;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_ERRFLAGS = 2'd2;

    localparam int CTRL_START_LSB  = 0;
    localparam int CTRL_ABORT_LSB  = 4;
    localparam int STAT_DONE_LSB   = 16;
    localparam int STAT_INIT_LSB   = 20;
    localparam int STAT_PROGB_LSB  = 24;
    localparam int ERR_TIMEOUT_LSB = 0;
    localparam int ERR_CRC_LSB     = 4;

    // Cycles SENSE waits so the 2-FF DONE synchronizer holds a real sample.
    localparam int SENSE_SETTLE_CYCLES = 2;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/glitc_config_fsm.sv
// One GLITC's configuration sequencer: DONE/INIT_B synchronizers, phase
// counter and the PROGRAM_B / INIT_B handshake state machine.
module glitc_config_fsm
    import glitc_config_pkg::*;
#(
    parameter int PROG_PULSE_CYCLES   = 64,
    parameter int INIT_HOLD_CYCLES    = 32,
    parameter int INIT_TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       done_i,
    input  logic       initPin_i,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       programB_o,
    output logic       initDriveLow_o,
    output logic       gready_o,
    output logic       timeout_o,
    output logic       crc_o,
    output logic [2:0] state_o,
    output logic       doneSync_o,
    output logic       initSync_o
);
    localparam int CNT_W = $clog2(maxOf3(PROG_PULSE_CYCLES, INIT_HOLD_CYCLES, INIT_TIMEOUT_CYCLES));
    localparam logic [CNT_W-1:0] SENSE_LAST   = CNT_W'(SENSE_SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] PROG_LAST    = CNT_W'(PROG_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(INIT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT_CYCLES - 1);

    glitcState_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       doneSync_q;
    logic [1:0]       initSync_q;
    logic             programB_q;
    logic             initLow_q;
    logic             gready_q;
    logic             timeout_q;
    logic             crc_q;
    logic             doneS;
    logic             initS;

    assign doneS = doneSync_q[1];
    assign initS = initSync_q[1];

    // gready_q is rewritten every cycle so it tracks the next state exactly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_SENSE;
            count_q    <= '0;
            doneSync_q <= '0;
            initSync_q <= '0;
            programB_q <= 1'b1;
            initLow_q  <= 1'b0;
            gready_q   <= 1'b0;
            timeout_q  <= 1'b0;
            crc_q      <= 1'b0;
        end else begin
            doneSync_q <= {doneSync_q[0], done_i};
            initSync_q <= {initSync_q[0], initPin_i};
            timeout_q  <= 1'b0;
            crc_q      <= 1'b0;
            gready_q   <= 1'b0;
            if (abort_i) begin
                state_q    <= ST_UNCONF;
                count_q    <= '0;
                programB_q <= 1'b1;
                initLow_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_SENSE: begin
                        if (count_q == SENSE_LAST) begin
                            count_q  <= '0;
                            state_q  <= doneS ? ST_READY : ST_UNCONF;
                            gready_q <= doneS;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    ST_UNCONF, ST_ERROR: begin
                        if (start_i) begin
                            state_q    <= ST_PROG;
                            count_q    <= '0;
                            programB_q <= 1'b0;
                            initLow_q  <= 1'b1;
                        end
                    end
                    ST_PROG: begin
                        if (count_q == PROG_LAST) begin
                            state_q    <= ST_HOLD;
                            count_q    <= '0;
                            programB_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (count_q == HOLD_LAST) begin
                            state_q   <= ST_WAIT_INIT;
                            count_q   <= '0;
                            initLow_q <= 1'b0;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    ST_WAIT_INIT: begin
                        if (initS) begin
                            state_q <= ST_LOAD;
                            count_q <= '0;
                        end else if (count_q == TIMEOUT_LAST) begin
                            state_q   <= ST_ERROR;
                            count_q   <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        // DONE takes priority: INIT_B may legitimately drop as the part wakes up.
                        if (doneS) begin
                            state_q  <= ST_READY;
                            gready_q <= 1'b1;
                        end else if (!initS) begin
                            state_q <= ST_ERROR;
                            crc_q   <= 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (start_i) begin
                            state_q    <= ST_PROG;
                            count_q    <= '0;
                            programB_q <= 1'b0;
                            initLow_q  <= 1'b1;
                        end else if (!doneS) begin
                            state_q <= ST_UNCONF;
                        end else begin
                            gready_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign programB_o     = programB_q;
    assign initDriveLow_o = initLow_q;
    assign gready_o       = gready_q;
    assign timeout_o      = timeout_q;
    assign crc_o          = crc_q;
    assign state_o        = state_q;
    assign doneSync_o     = doneS;
    assign initSync_o     = initS;

endmodule

// File: rtl/glitc_config_controller.sv
// Wishbone-controlled configuration pin owner for four GLITCs; feeds the
// GLITCBUS master's gready vector.
module glitc_config_controller
    import glitc_config_pkg::*;
#(
    parameter int NUM_GLITC           = 4,
    parameter int PROG_PULSE_CYCLES   = 64,
    parameter int INIT_HOLD_CYCLES    = 32,
    parameter int INIT_TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [3:0]           adr_i,
    input  logic [31:0]          dat_i,
    input  logic [3:0]           sel_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic                 rty_o,
    output logic [NUM_GLITC-1:0] PROGRAM_B,
    inout  wire  [NUM_GLITC-1:0] INIT_B,
    input  logic [NUM_GLITC-1:0] DONE,
    output logic [NUM_GLITC-1:0] gready_o
);
    logic [1:0]             regSel;
    logic                   wbReq;
    logic                   wrEn;
    logic [NUM_GLITC-1:0]   startPulse;
    logic [NUM_GLITC-1:0]   abortPulse;
    logic [NUM_GLITC-1:0]   errClearTimeout;
    logic [NUM_GLITC-1:0]   errClearCrc;
    logic [NUM_GLITC-1:0]   initDriveLow;
    logic [NUM_GLITC-1:0]   timeoutEvt;
    logic [NUM_GLITC-1:0]   crcEvt;
    logic [NUM_GLITC-1:0]   doneSync;
    logic [NUM_GLITC-1:0]   initSync;
    logic [3*NUM_GLITC-1:0] statePacked;
    logic [NUM_GLITC-1:0]   timeoutFlag_q;
    logic [NUM_GLITC-1:0]   crcFlag_q;
    logic                   ack_q;
    logic [31:0]            dat_q;
    logic [31:0]            readData;
    logic                   unusedBits;

    assign regSel = adr_i[3:2];
    assign wbReq  = cyc_i & stb_i & ~ack_q;
    assign wrEn   = wbReq & we_i;

    assign startPulse      = (wrEn && regSel == REG_CTRL)     ? dat_i[CTRL_START_LSB  +: NUM_GLITC] : '0;
    assign abortPulse      = (wrEn && regSel == REG_CTRL)     ? dat_i[CTRL_ABORT_LSB  +: NUM_GLITC] : '0;
    assign errClearTimeout = (wrEn && regSel == REG_ERRFLAGS) ? dat_i[ERR_TIMEOUT_LSB +: NUM_GLITC] : '0;
    assign errClearCrc     = (wrEn && regSel == REG_ERRFLAGS) ? dat_i[ERR_CRC_LSB     +: NUM_GLITC] : '0;

    for (genvar g = 0; g < NUM_GLITC; g++) begin : gGlitc
        glitc_config_fsm #(
            .PROG_PULSE_CYCLES  (PROG_PULSE_CYCLES),
            .INIT_HOLD_CYCLES   (INIT_HOLD_CYCLES),
            .INIT_TIMEOUT_CYCLES(INIT_TIMEOUT_CYCLES)
        ) uFsm (
            .clk_i         (clk_i),
            .rst_n_i       (rst_n_i),
            .done_i        (DONE[g]),
            .initPin_i     (INIT_B[g]),
            .start_i       (startPulse[g]),
            .abort_i       (abortPulse[g]),
            .programB_o    (PROGRAM_B[g]),
            .initDriveLow_o(initDriveLow[g]),
            .gready_o      (gready_o[g]),
            .timeout_o     (timeoutEvt[g]),
            .crc_o         (crcEvt[g]),
            .state_o       (statePacked[3*g +: 3]),
            .doneSync_o    (doneSync[g]),
            .initSync_o    (initSync[g])
        );
        assign INIT_B[g] = initDriveLow[g] ? 1'b0 : 1'bz;
    end

    always_comb begin
        readData = '0;
        case (regSel)
            REG_CTRL:     readData[NUM_GLITC-1:0] = gready_o;
            REG_STATUS: begin
                readData[3*NUM_GLITC-1:0]              = statePacked;
                readData[STAT_DONE_LSB  +: NUM_GLITC] = doneSync;
                readData[STAT_INIT_LSB  +: NUM_GLITC] = initSync;
                readData[STAT_PROGB_LSB +: NUM_GLITC] = PROGRAM_B;
            end
            REG_ERRFLAGS: begin
                readData[ERR_TIMEOUT_LSB +: NUM_GLITC] = timeoutFlag_q;
                readData[ERR_CRC_LSB     +: NUM_GLITC] = crcFlag_q;
            end
            default:      readData = '0;
        endcase
    end

    // A flag event landing in the same cycle as its write-1-to-clear survives.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q         <= 1'b0;
            dat_q         <= '0;
            timeoutFlag_q <= '0;
            crcFlag_q     <= '0;
        end else begin
            ack_q         <= wbReq;
            dat_q         <= wbReq ? readData : '0;
            timeoutFlag_q <= (timeoutFlag_q & ~errClearTimeout) | timeoutEvt;
            crcFlag_q     <= (crcFlag_q & ~errClearCrc) | crcEvt;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign err_o = 1'b0;
    assign rty_o = 1'b0;

    assign unusedBits = ^{sel_i, adr_i[1:0], dat_i[31:8]};

endmodule

// File: tb/tb_glitc_config_controller.sv
// Directed, table-driven bench for glitc_config_controller with an
// open-drain INIT_B model (pull-up plus per-GLITC external pull-down).
module tb_glitc_config_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        ack, err, rty;
    logic [3:0]  progB;
    tri   [3:0]  initB;
    logic [3:0]  done;
    logic [3:0]  gready;
    logic [3:0]  extLow;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd;
    logic        gotAck;
    int          progLowCnt;
    int          initLowCnt;
    logic [2:0]  ackSeq;
    logic [31:0] firstAckData;

    typedef struct {
        string       name;
        logic [3:0]  adr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] expRead;
        logic [3:0]  expGready;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gPin
        assign initB[g] = extLow[g] ? 1'b0 : 1'bz;
        pullup (initB[g]);
    end

    glitc_config_controller dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .cyc_i    (cyc),
        .stb_i    (stb),
        .we_i     (we),
        .adr_i    (adr),
        .dat_i    (wdat),
        .sel_i    (sel),
        .dat_o    (rdat),
        .ack_o    (ack),
        .err_o    (err),
        .rty_o    (rty),
        .PROGRAM_B(progB),
        .INIT_B   (initB),
        .DONE     (done),
        .gready_o (gready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Single Wishbone access: request at a negedge, ack sampled at the following negedge.
    task automatic applyStimulus(input logic [3:0] a, input logic w, input logic [31:0] d,
                                 output logic [31:0] rdOut, output logic ackOut);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        @(negedge clk);
        ackOut = ack;
        rdOut  = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wbWrite(input string name, input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        k;
        applyStimulus(a, 1'b1, d, r, k);
        checkOutput({name, " ack"}, {31'b0, k}, 32'd1);
    endtask

    task automatic wbReadCheck(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        k;
        applyStimulus(a, 1'b0, 32'h0, r, k);
        checkOutput({name, " ack"}, {31'b0, k}, 32'd1);
        checkOutput(name, r, exp);
    endtask

    task automatic stateCheck(input string name, input int k, input logic [2:0] exp);
        logic [31:0] r;
        logic        a;
        applyStimulus(4'h4, 1'b0, 32'h0, r, a);
        checkOutput(name, (r >> (3 * k)) & 32'h7, {29'b0, exp});
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{"ctrl read",          4'h0, 1'b0, 32'h0,        32'h0000_0005, 4'b0101};
        vecs[1]  = '{"status read",        4'h4, 1'b0, 32'h0,        32'h0FF5_0145, 4'b0101};
        vecs[2]  = '{"status low adr bits",4'h7, 1'b0, 32'h0,        32'h0FF5_0145, 4'b0101};
        vecs[3]  = '{"errflags read",      4'h8, 1'b0, 32'h0,        32'h0000_0000, 4'b0101};
        vecs[4]  = '{"offset C read",      4'hC, 1'b0, 32'h0,        32'h0000_0000, 4'b0101};
        vecs[5]  = '{"offset C write",     4'hC, 1'b1, 32'hFFFF_FFFF, 32'h0,        4'b0101};
        vecs[6]  = '{"offset C reread",    4'hC, 1'b0, 32'h0,        32'h0000_0000, 4'b0101};
        vecs[7]  = '{"errflags clear all", 4'h8, 1'b1, 32'h0000_00FF, 32'h0,        4'b0101};
        vecs[8]  = '{"errflags reread",    4'h8, 1'b0, 32'h0,        32'h0000_0000, 4'b0101};
        vecs[9]  = '{"ctrl write none",    4'h0, 1'b1, 32'h0,        32'h0,         4'b0101};
        vecs[10] = '{"ctrl reread",        4'h0, 1'b0, 32'h0,        32'h0000_0005, 4'b0101};

        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 4'h0; wdat = 32'h0;
        sel = 4'hF; done = 4'b0101; extLow = 4'b0000;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset PROGRAM_B", {28'b0, progB}, 32'hF);
        checkOutput("reset INIT_B released", {28'b0, initB}, 32'hF);
        checkOutput("reset gready", {28'b0, gready}, 32'h0);
        checkOutput("reset ack", {31'b0, ack}, 32'h0);
        checkOutput("reset dat_o", rdat, 32'h0);
        checkOutput("err_o tied", {31'b0, err}, 32'h0);
        checkOutput("rty_o tied", {31'b0, rty}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("sensed gready", {28'b0, gready}, 32'h5);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].adr, vecs[i].we, vecs[i].wdata, rd, gotAck);
            checkOutput({vecs[i].name, " ack"}, {31'b0, gotAck}, 32'd1);
            if (!vecs[i].we)
                checkOutput(vecs[i].name, rd, vecs[i].expRead);
            checkOutput({vecs[i].name, " gready"}, {28'b0, gready}, {28'b0, vecs[i].expGready});
        end

        // GLITC 0 loses DONE, then goes through a full programming sequence
        done[0] = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("done loss gready", {28'b0, gready}, 32'h4);
        stateCheck("done loss state0", 0, 3'd0);
        wbWrite("start0", 4'h0, 32'h1);
        progLowCnt = 0;
        initLowCnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (progB[0] === 1'b0) progLowCnt++;
            if (initB[0] === 1'b0) initLowCnt++;
            else break;
            @(negedge clk);
        end
        extLow[0] = 1'b1;
        checkOutput("PROGRAM_B low cycles", progLowCnt, 32'd64);
        checkOutput("INIT_B low cycles", initLowCnt, 32'd96);
        repeat (6) @(negedge clk);
        stateCheck("state0 wait_init", 0, 3'd3);
        extLow[0] = 1'b0;
        repeat (5) @(negedge clk);
        stateCheck("state0 load", 0, 3'd4);
        wbWrite("start0 in load", 4'h0, 32'h1);
        stateCheck("start ignored in load", 0, 3'd4);
        done[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("gready0 after done", {31'b0, gready[0]}, 32'd1);
        stateCheck("state0 ready", 0, 3'd5);

        // GLITC 2 times out waiting for INIT_B
        done[2] = 1'b0;
        extLow[2] = 1'b1;
        repeat (5) @(negedge clk);
        wbWrite("start2", 4'h0, 32'h4);
        repeat (4090) @(negedge clk);
        stateCheck("state2 before timeout", 2, 3'd3);
        repeat (200) @(negedge clk);
        stateCheck("state2 timeout error", 2, 3'd6);
        wbReadCheck("errflags timeout2", 4'h8, 32'h4);
        wbWrite("clear timeout2", 4'h8, 32'h4);
        wbReadCheck("errflags after clear", 4'h8, 32'h0);
        extLow[2] = 1'b0;

        // GLITC 1: INIT_B drops during LOAD -> crc error
        wbWrite("start1", 4'h0, 32'h2);
        repeat (110) @(negedge clk);
        stateCheck("state1 load", 1, 3'd4);
        extLow[1] = 1'b1;
        repeat (6) @(negedge clk);
        stateCheck("state1 crc error", 1, 3'd6);
        wbReadCheck("errflags crc1", 4'h8, 32'h20);
        wbWrite("clear crc1", 4'h8, 32'h20);
        wbReadCheck("errflags crc cleared", 4'h8, 32'h0);

        // GLITC 1: INIT_B drop together with DONE rise -> DONE wins
        extLow[1] = 1'b0;
        wbWrite("restart1", 4'h0, 32'h2);
        repeat (110) @(negedge clk);
        stateCheck("state1 load again", 1, 3'd4);
        extLow[1] = 1'b1;
        done[1] = 1'b1;
        repeat (6) @(negedge clk);
        stateCheck("state1 ready via done", 1, 3'd5);
        wbReadCheck("no crc flag", 4'h8, 32'h0);
        checkOutput("gready1", {31'b0, gready[1]}, 32'd1);
        extLow[1] = 1'b0;

        // Abort beats start on GLITC 0
        wbWrite("start0 again", 4'h0, 32'h1);
        checkOutput("PROGRAM_B0 low in prog", {31'b0, progB[0]}, 32'd0);
        repeat (5) @(negedge clk);
        wbWrite("start+abort0", 4'h0, 32'h11);
        checkOutput("PROGRAM_B0 after abort", {31'b0, progB[0]}, 32'd1);
        checkOutput("INIT_B0 after abort", {31'b0, initB[0]}, 32'd1);
        stateCheck("state0 aborted", 0, 3'd0);

        // Back-to-back reads with cyc/stb held
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ackSeq[i] = ack;
            if (i == 0) firstAckData = rdat;
        end
        cyc = 1'b0; stb = 1'b0;
        checkOutput("back-to-back ack", {29'b0, ackSeq}, 32'b101);
        checkOutput("back-to-back data", firstAckData, 32'h2);

        // Reset asserted mid-programming releases pins immediately
        wbWrite("start3", 4'h0, 32'h8);
        checkOutput("PROGRAM_B3 low", {31'b0, progB[3]}, 32'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset PROGRAM_B", {28'b0, progB}, 32'hF);
        checkOutput("async reset INIT_B", {28'b0, initB}, 32'hF);
        checkOutput("async reset gready", {28'b0, gready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wbReadCheck("status after re-sense", 4'h4, 32'h0FF3_002D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
